// File: rtl/seven_segment_display_scanner.sv
// Three-digit multiplexed seven-segment driver with a power-of-two scan-rate divider.
// Enable and segment outputs are registered together so digit and data never disagree.
module seven_segment_display_scanner #(
  parameter int POWER_OF_TWO_DIV = 65536
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_HexLutEn,
  input  logic [6:0] i_SegOne,
  input  logic [6:0] i_SegTwo,
  input  logic [6:0] i_SegThree,
  output logic [2:0] o_7Seg_En,
  output logic [6:0] o_7Seg_Led
);

  localparam int CntW = (POWER_OF_TWO_DIV > 1) ? $clog2(POWER_OF_TWO_DIV) : 1;

  generate
    if (POWER_OF_TWO_DIV < 2 || (POWER_OF_TWO_DIV & (POWER_OF_TWO_DIV - 1)) != 0) begin : g_badDiv
      $error("POWER_OF_TWO_DIV must be a power of two and at least 2");
    end
  endgenerate

  // Glyph table indexed by nibble; bit0 = segment a ... bit6 = segment g.
  localparam logic [6:0] HexLut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic [CntW-1:0] divCnt;
  logic            tick;
  logic [1:0]      digitIdx;
  logic [6:0]      selSeg;
  logic [6:0]      glyph;
  logic [2:0]      enNext;

  // Counter wraps naturally, so the terminal count is simply all ones.
  assign tick = &divCnt;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    selSeg = '0;
    enNext = '0;
    case (digitIdx)
      2'd0:    begin selSeg = i_SegOne;   enNext = 3'b001; end
      2'd1:    begin selSeg = i_SegTwo;   enNext = 3'b010; end
      2'd2:    begin selSeg = i_SegThree; enNext = 3'b100; end
      default: begin selSeg = '0;         enNext = 3'b000; end
    endcase
    glyph = i_HexLutEn ? HexLut[selSeg[3:0]] : selSeg;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      divCnt     <= '0;
      digitIdx   <= 2'd0;
      o_7Seg_En  <= 3'b000;
      o_7Seg_Led <= 7'h00;
    end else begin
      divCnt <= divCnt + 1'b1;
      if (digitIdx == 2'd3) begin
        digitIdx <= 2'd0;
      end else if (tick) begin
        digitIdx <= (digitIdx == 2'd2) ? 2'd0 : digitIdx + 2'd1;
      end
      o_7Seg_En  <= enNext;
      o_7Seg_Led <= glyph;
    end
  end

endmodule

// File: tb/tb_seven_segment_display_scanner.sv
// Directed and randomized bench for seven_segment_display_scanner with a divide-by-4 scan.
// Expected outputs come from an edge-count model: digit = (edges / DIV) mod 3, one edge of output latency.
module tb_seven_segment_display_scanner;

  localparam int Div = 4;

  logic       i_Clk;
  logic       i_Rst_n;
  logic       i_HexLutEn;
  logic [6:0] i_SegOne;
  logic [6:0] i_SegTwo;
  logic [6:0] i_SegThree;
  logic [2:0] o_7Seg_En;
  logic [6:0] o_7Seg_Led;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  logic [2:0] lastExpEn = 3'b000;

  logic [6:0] hexLut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seven_segment_display_scanner #(.POWER_OF_TWO_DIV(Div)) dut (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_HexLutEn (i_HexLutEn),
    .i_SegOne   (i_SegOne),
    .i_SegTwo   (i_SegTwo),
    .i_SegThree (i_SegThree),
    .o_7Seg_En  (o_7Seg_En),
    .o_7Seg_Led (o_7Seg_Led)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] refGlyph(input logic hex, input logic [6:0] v);
    return hex ? hexLut[v[3:0]] : v;
  endfunction

  // Predict the next edge from the current inputs and edge count, clock once, then compare.
  task automatic stepAndCheck(input string tag);
    int idx;
    logic [6:0] sel;
    logic [2:0] expEn;
    logic [6:0] expLed;
    idx = (edges / Div) % 3;
    sel = (idx == 0) ? i_SegOne : (idx == 1) ? i_SegTwo : i_SegThree;
    expEn  = 3'(1 << idx);
    expLed = refGlyph(i_HexLutEn, sel);
    @(posedge i_Clk);
    edges++;
    #1;
    lastExpEn = expEn;
    check({tag, "_en"}, {4'b0, o_7Seg_En}, {4'b0, expEn});
    check({tag, "_led"}, o_7Seg_Led, expLed);
  endtask

  task automatic advanceTo(input logic [2:0] wantEn, input string tag);
    int budget;
    budget = 0;
    stepAndCheck(tag);
    while (lastExpEn != wantEn && budget < 20) begin
      stepAndCheck(tag);
      budget++;
    end
    checks++;
    if (budget >= 20) begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected<20", tag, budget);
    end
  endtask

  initial begin
    i_Rst_n    = 1'b0;
    i_HexLutEn = 1'b0;
    i_SegOne   = 7'h01;
    i_SegTwo   = 7'h02;
    i_SegThree = 7'h04;

    // Reset held for five clocks.
    for (int i = 0; i < 5; i++) begin
      @(posedge i_Clk);
      #1;
      check("rst_en", {4'b0, o_7Seg_En}, 7'h00);
      check("rst_led", o_7Seg_Led, 7'h00);
    end
    i_Rst_n = 1'b1;
    edges   = 0;

    // Raw-mode scan through all three digits and back to digit 0.
    for (int i = 0; i < 13; i++) stepAndCheck("scan");
    check("scan_wrap_en", {4'b0, o_7Seg_En}, 7'h01);

    // Hex LUT mode; upper bits of digit 0 must be ignored.
    i_HexLutEn = 1'b1;
    i_SegOne   = 7'h70;
    i_SegTwo   = 7'h0A;
    i_SegThree = 7'h0F;
    for (int i = 0; i < 12; i++) stepAndCheck("lut");

    // Mode switch while digit 1 is displayed.
    advanceTo(3'b010, "goto_d1");
    i_HexLutEn = 1'b0;
    i_SegTwo   = 7'h08;
    stepAndCheck("raw08");
    check("raw08_led_const", o_7Seg_Led, 7'h08);
    i_HexLutEn = 1'b1;
    stepAndCheck("mode");
    check("mode_led_const", o_7Seg_Led, 7'h7F);
    check("mode_en_const", {4'b0, o_7Seg_En}, 7'h02);

    // Input change while digit 0 is displayed.
    advanceTo(3'b001, "goto_d0");
    i_HexLutEn = 1'b0;
    i_SegOne   = 7'h55;
    stepAndCheck("segone");
    check("segone_led_const", o_7Seg_Led, 7'h55);

    // Asynchronous reset between edges while digit 2 is displayed.
    advanceTo(3'b100, "goto_d2");
    #2;
    i_Rst_n = 1'b0;
    #1;
    check("async_en", {4'b0, o_7Seg_En}, 7'h00);
    check("async_led", o_7Seg_Led, 7'h00);
    @(posedge i_Clk);
    #1;
    check("async_hold_en", {4'b0, o_7Seg_En}, 7'h00);
    i_Rst_n = 1'b1;
    edges   = 0;
    for (int i = 0; i < 5; i++) stepAndCheck("resume");
    check("resume_en_const", {4'b0, o_7Seg_En}, 7'h02);

    // Randomized inputs and mode, changing between edges.
    for (int i = 0; i < 90; i++) begin
      i_SegOne   = 7'($urandom);
      i_SegTwo   = 7'($urandom);
      i_SegThree = 7'($urandom);
      if ($urandom_range(0, 3) == 0) i_HexLutEn = 1'($urandom);
      stepAndCheck("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
